sram_access_ctrl: RTL and testbench

Request-level sequencer placed directly upstream of the column write driver and sense amplifiers in the mixed-signal SRAM macro. It accepts one read or write request at a time over a valid/ready handshake and drives the timed analog control phases: precharge, wordline, write-drive and sense-enable. It also supplies the registered `data_in` bus consumed by the write driver and returns captured read data.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/wl_decoder.sv | 19 +
 rtl/sram_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_access_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM access controller.
package sram_ctrl_pkg;

   // Controller phases; each timed phase is measured by one shared counter.
   typedef enum logic [2:0] {
      IDLE,
      PRECHARGE,
      WRITE,
      READ_WL,
      SENSE
   } state_t;

   // Width of the phase counter: wide enough for the longest phase length.
   function automatic int phase_cnt_w(input int pre_cyc, input int wl_cyc, input int sa_cyc);
      int m;
      m = pre_cyc;
      if (wl_cyc > m) m = wl_cyc;
      if (sa_cyc > m) m = sa_cyc;
      return ($clog2(m + 1) > 1) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/wl_decoder.sv
// One-hot wordline decoder; rows at or beyond ROWS select nothing.
module wl_decoder #(
   parameter int ROWS = 16,
   parameter int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic [AW-1:0]   addr,
   input  logic            en,
   output logic [ROWS-1:0] wl
);

   // Decode the row address into a single wordline when enabled.
   always_comb begin
      wl = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (en && (addr == AW'(i))) wl[i] = 1'b1;
      end
   end

endmodule

// File: rtl/sram_access_ctrl.sv
// Request-level sequencer for the SRAM macro: runs precharge, wordline,
// write-drive and sense phases for one request at a time. Every output is
// registered from the next-state decode so the analog controls are glitch-free.
module sram_access_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int COLS    = 8,
   parameter int ROWS    = 16,
   parameter int PRE_CYC = 1,
   parameter int WL_CYC  = 2,
   parameter int SA_CYC  = 1,
   localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [COLS-1:0] req_wdata,
   output logic [COLS-1:0] data_in,
   output logic            wr_en,
   output logic            pre_en,
   output logic [ROWS-1:0] wl,
   output logic            sae,
   input  logic [COLS-1:0] sa_out,
   output logic            rsp_valid,
   output logic [COLS-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int CW = phase_cnt_w(PRE_CYC, WL_CYC, SA_CYC);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic            err_q;
   logic            accept;
   logic            last;
   logic            sense_done;
   logic            wl_en;
   logic [ROWS-1:0] wl_nx;

   assign accept     = req_valid && req_ready;
   assign last       = (cnt == '0);
   assign sense_done = (state == SENSE) && last;
   assign wl_en      = (state_nx == WRITE) || (state_nx == READ_WL);

   // Next phase and counter reload; the counter counts down to zero in each timed phase.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = PRECHARGE;
               cnt_nx   = CW'(PRE_CYC - 1);
            end
         end
         PRECHARGE: begin
            if (last) begin
               state_nx = we_q ? WRITE : READ_WL;
               cnt_nx   = CW'(WL_CYC - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         WRITE: begin
            if (last) state_nx = IDLE;
            else      cnt_nx   = cnt - CW'(1);
         end
         READ_WL: begin
            if (last) begin
               state_nx = SENSE;
               cnt_nx   = CW'(SA_CYC - 1);
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         SENSE: begin
            if (last) state_nx = IDLE;
            else      cnt_nx   = cnt - CW'(1);
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   wl_decoder #(
      .ROWS (ROWS),
      .AW   (AW)
   ) u_wl_decoder (
      .addr (addr_q),
      .en   (wl_en),
      .wl   (wl_nx)
   );

   // Phase state and registered array controls; reset drops every control at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         pre_en    <= 1'b0;
         wr_en     <= 1'b0;
         sae       <= 1'b0;
         wl        <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         req_ready <= (state_nx == IDLE);
         pre_en    <= (state_nx == PRECHARGE);
         wr_en     <= (state_nx == WRITE);
         sae       <= (state_nx == SENSE);
         wl        <= wl_nx;
         rsp_valid <= sense_done;
         if (sense_done) rsp_err <= err_q;
      end
   end

   // Write-driver data and captured read data; out-of-range reads return zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_in   <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept && req_we) data_in   <= req_wdata;
         if (sense_done)       rsp_rdata <= err_q ? '0 : sa_out;
      end
   end

   // Request fields held for the duration of the operation.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q   <= req_we;
         addr_q <= req_addr;
         err_q  <= ({1'b0, req_addr} >= (AW + 1)'(ROWS));
      end
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: instance 0 uses default timing with 16 rows,
// instance 1 uses 12 rows with PRE_CYC=3, WL_CYC=1, SA_CYC=2. A timeline model
// predicts every output per cycle from accepted requests; a toy array model
// supplies sa_out from what the DUT actually wrote.
module tb_sram_access_ctrl;

   localparam int N = 4096;

   logic clk = 1'b0;
   logic rst;

   logic       vld  [2];
   logic       we   [2];
   logic [3:0] addr [2];
   logic [7:0] wd   [2];
   logic [7:0] sa   [2];

   logic        rdy_o [2];
   logic [7:0]  din_o [2];
   logic        wr_o  [2];
   logic        pre_o [2];
   logic        sae_o [2];
   logic        rv_o  [2];
   logic [7:0]  rd_o  [2];
   logic        re_o  [2];
   logic [15:0] wl_a;
   logic [11:0] wl_b;
   logic [15:0] wl_o  [2];

   assign wl_o[0] = wl_a;
   assign wl_o[1] = {4'b0000, wl_b};

   always #5 clk = ~clk;

   sram_access_ctrl #(.COLS(8), .ROWS(16), .PRE_CYC(1), .WL_CYC(2), .SA_CYC(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy_o[0]), .req_we(we[0]),
      .req_addr(addr[0]), .req_wdata(wd[0]), .data_in(din_o[0]), .wr_en(wr_o[0]),
      .pre_en(pre_o[0]), .wl(wl_a), .sae(sae_o[0]), .sa_out(sa[0]),
      .rsp_valid(rv_o[0]), .rsp_rdata(rd_o[0]), .rsp_err(re_o[0])
   );

   sram_access_ctrl #(.COLS(8), .ROWS(12), .PRE_CYC(3), .WL_CYC(1), .SA_CYC(2)) dut1 (
      .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy_o[1]), .req_we(we[1]),
      .req_addr(addr[1]), .req_wdata(wd[1]), .data_in(din_o[1]), .wr_en(wr_o[1]),
      .pre_en(pre_o[1]), .wl(wl_b), .sae(sae_o[1]), .sa_out(sa[1]),
      .rsp_valid(rv_o[1]), .rsp_rdata(rd_o[1]), .rsp_err(re_o[1])
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, i, $time, act, exp);
   endtask

   function automatic int p_cyc(input int i); return (i == 0) ? 1 : 3; endfunction
   function automatic int w_cyc(input int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int s_cyc(input int i); return (i == 0) ? 1 : 2; endfunction
   function automatic int n_rows(input int i); return (i == 0) ? 16 : 12; endfunction

   // Expected per-cycle outputs; index = cycle number counted in clock edges.
   logic        e_rdy [2][N];
   logic        e_pre [2][N];
   logic        e_wr  [2][N];
   logic        e_sae [2][N];
   logic        e_rv  [2][N];
   logic        e_err [2][N];
   logic [7:0]  e_rd  [2][N];
   logic [7:0]  e_din [2][N];
   logic [15:0] e_wl  [2][N];
   logic [7:0]  ref_mem [2][16];
   int          cyc = 0;
   bit          started = 0;

   task automatic clear_from(input int i, input int from);
      for (int k = from; k < N; k++) begin
         e_rdy[i][k] = 1'b1; e_pre[i][k] = 1'b0; e_wr[i][k] = 1'b0; e_sae[i][k] = 1'b0;
         e_rv[i][k] = 1'b0; e_err[i][k] = 1'b0; e_rd[i][k] = 8'h00; e_din[i][k] = 8'h00;
         e_wl[i][k] = 16'h0000;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         clear_from(i, 0);
         for (int r = 0; r < 16; r++) ref_mem[i][r] = 8'h00;
      end
   end

   // Timeline model: on each edge, either reset or schedule an accepted request.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            clear_from(i, cyc + 1);
            if (cyc + 1 < N) e_rdy[i][cyc + 1] = 1'b0;
         end else if (vld[i] && e_rdy[i][cyc]) begin
            int k;
            int a;
            bit inr;
            a   = int'(addr[i]);
            inr = (a < n_rows(i));
            k   = cyc + 1;
            for (int j = 0; j < p_cyc(i); j++) begin
               if (k < N) begin e_pre[i][k] = 1'b1; e_rdy[i][k] = 1'b0; end
               k++;
            end
            for (int j = 0; j < w_cyc(i); j++) begin
               if (k < N) begin
                  e_wl[i][k]  = inr ? (16'h0001 << a) : 16'h0000;
                  e_wr[i][k]  = we[i];
                  e_rdy[i][k] = 1'b0;
               end
               k++;
            end
            if (!we[i]) begin
               for (int j = 0; j < s_cyc(i); j++) begin
                  if (k < N) begin e_sae[i][k] = 1'b1; e_rdy[i][k] = 1'b0; end
                  k++;
               end
               if (k < N) begin
                  e_rv[i][k]  = 1'b1;
                  e_rd[i][k]  = inr ? ref_mem[i][a] : 8'h00;
                  e_err[i][k] = !inr;
               end
            end else begin
               for (int q = cyc + 1; q < N; q++) e_din[i][q] = wd[i];
               if (inr) ref_mem[i][a] = wd[i];
            end
         end
      end
      if (rst) started = 1;
      cyc++;
   end

   // Toy bit-cell array: stores what the DUT drives, senses the last selected row.
   logic [7:0] marr [2][16];
   int         mrow [2];
   bit         mrowv [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         mrow[i] = 0; mrowv[i] = 0;
         for (int r = 0; r < 16; r++) marr[i][r] = 8'h00;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (pre_o[i]) mrowv[i] = 0;
         for (int b = 0; b < 16; b++) begin
            if (wl_o[i][b]) begin
               mrow[i]  = b;
               mrowv[i] = 1;
               if (wr_o[i]) marr[i][b] = din_o[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sa[i] = 8'hEE;
         if (sae_o[i] && mrowv[i]) sa[i] = marr[i][mrow[i]];
      end
   end

   // Per-cycle compare against the model plus the structural invariants.
   always @(negedge clk) begin
      if (started && cyc < N) begin
         for (int i = 0; i < 2; i++) begin
            chk("req_ready", i, 32'(rdy_o[i]), 32'(e_rdy[i][cyc]));
            chk("pre_en",    i, 32'(pre_o[i]), 32'(e_pre[i][cyc]));
            chk("wl",        i, 32'(wl_o[i]),  32'(e_wl[i][cyc]));
            chk("wr_en",     i, 32'(wr_o[i]),  32'(e_wr[i][cyc]));
            chk("sae",       i, 32'(sae_o[i]), 32'(e_sae[i][cyc]));
            chk("data_in",   i, 32'(din_o[i]), 32'(e_din[i][cyc]));
            chk("rsp_valid", i, 32'(rv_o[i]),  32'(e_rv[i][cyc]));
            if (e_rv[i][cyc]) begin
               chk("rsp_rdata", i, 32'(rd_o[i]), 32'(e_rd[i][cyc]));
               chk("rsp_err",   i, 32'(re_o[i]), 32'(e_err[i][cyc]));
            end
            chk("excl", i, 32'((int'(pre_o[i]) + int'(wl_o[i] != 0) + int'(sae_o[i])) <= 1), 32'd1);
            chk("onehot_wl", i, 32'($onehot0(wl_o[i])), 32'd1);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until an edge where the controller is ready.
   task automatic op(input int i, input bit w, input int a, input int d);
      bit acc;
      bit r;
      acc = 0;
      vld[i] = 1'b1; we[i] = w; addr[i] = 4'(a); wd[i] = 8'(d);
      for (int n = 0; n < 60 && !acc; n++) begin
         @(negedge clk);
         r = rdy_o[i];
         tick;
         if (r) acc = 1;
      end
      vld[i] = 1'b0;
      chk("accept_timeout", i, 32'(acc), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; we[i] = 1'b0; addr[i] = 4'h0; wd[i] = 8'h00;
      end
      repeat (3) tick;
      @(negedge clk);
      chk("lit_rdy_in_rst", 0, 32'(rdy_o[0]), 32'd0);
      rst = 1'b0;
      tick;
      @(negedge clk);
      chk("lit_rdy_after_rst", 0, 32'(rdy_o[0]), 32'd1);
      chk("lit_rdy_after_rst", 1, 32'(rdy_o[1]), 32'd1);

      // Write row 3 with 0xA5.
      vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd3; wd[0] = 8'hA5;
      tick; vld[0] = 1'b0;
      @(negedge clk);
      chk("lit_wr_pre_c1", 0, 32'(pre_o[0]), 32'd1);
      chk("lit_wr_din_c1", 0, 32'(din_o[0]), 32'hA5);
      tick; @(negedge clk);
      chk("lit_wr_wl_c2", 0, 32'(wl_o[0]), 32'h0008);
      chk("lit_wr_en_c2", 0, 32'(wr_o[0]), 32'd1);
      tick; @(negedge clk);
      chk("lit_wr_wl_c3", 0, 32'(wl_o[0]), 32'h0008);
      tick; @(negedge clk);
      chk("lit_wr_rdy_c4", 0, 32'(rdy_o[0]), 32'd1);
      chk("lit_wr_wl_c4", 0, 32'(wl_o[0]), 32'h0000);

      // Read row 3 back.
      vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd3;
      tick; vld[0] = 1'b0;
      repeat (2) tick;
      tick; @(negedge clk);
      chk("lit_rd_sae_c4", 0, 32'(sae_o[0]), 32'd1);
      tick; @(negedge clk);
      chk("lit_rd_rv_c5", 0, 32'(rv_o[0]), 32'd1);
      chk("lit_rd_data_c5", 0, 32'(rd_o[0]), 32'hA5);
      chk("lit_rd_err_c5", 0, 32'(re_o[0]), 32'd0);
      tick; @(negedge clk);
      chk("lit_rd_rv_c6", 0, 32'(rv_o[0]), 32'd0);

      // Back-to-back: write row 0 with 0x5A, then read row 15.
      vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd0; wd[0] = 8'h5A;
      tick; we[0] = 1'b0; addr[0] = 4'd15;
      repeat (3) tick;
      @(negedge clk);
      chk("lit_b2b_rdy_c4", 0, 32'(rdy_o[0]), 32'd1);
      tick; vld[0] = 1'b0;
      @(negedge clk);
      chk("lit_b2b_din_c5", 0, 32'(din_o[0]), 32'h5A);
      tick; @(negedge clk);
      chk("lit_b2b_wl_c6", 0, 32'(wl_o[0]), 32'h8000);
      tick; @(negedge clk);
      chk("lit_b2b_wl_c7", 0, 32'(wl_o[0]), 32'h8000);
      repeat (2) tick;
      @(negedge clk);
      chk("lit_b2b_rv_c9", 0, 32'(rv_o[0]), 32'd1);
      chk("lit_b2b_din_c9", 0, 32'(din_o[0]), 32'h5A);

      // Reset in the middle of a write.
      tick;
      vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd5; wd[0] = 8'h3C;
      tick; vld[0] = 1'b0;
      tick; @(negedge clk);
      chk("lit_abort_wl_c2", 0, 32'(wl_o[0]), 32'h0020);
      rst = 1'b1;
      tick; @(negedge clk);
      chk("lit_abort_wl", 0, 32'(wl_o[0]), 32'h0000);
      chk("lit_abort_wr", 0, 32'(wr_o[0]), 32'd0);
      chk("lit_abort_rdy", 0, 32'(rdy_o[0]), 32'd0);
      rst = 1'b0;
      tick; @(negedge clk);
      chk("lit_abort_rdy_after", 0, 32'(rdy_o[0]), 32'd1);

      // Row 0 survives the abort; read it back through the model.
      op(0, 1'b0, 0, 0);
      repeat (8) tick;

      // Instance 1: write row 2, then read out-of-range row 13.
      op(1, 1'b1, 2, 8'h77);
      repeat (8) tick;
      vld[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd13;
      tick; vld[1] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk("lit_oor_wl", 1, 32'(wl_o[1]), 32'h0000);
         if (k == 7) begin
            chk("lit_oor_rv_c7", 1, 32'(rv_o[1]), 32'd1);
            chk("lit_oor_data_c7", 1, 32'(rd_o[1]), 32'h00);
            chk("lit_oor_err_c7", 1, 32'(re_o[1]), 32'd1);
         end else begin
            chk("lit_oor_rv_early", 1, 32'(rv_o[1]), 32'd0);
         end
         tick;
      end
      op(1, 1'b0, 2, 0);

      // Mixed traffic on both instances, including out-of-range rows.
      for (int n = 0; n < 40; n++) begin
         op(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) tick;
      end
      for (int n = 0; n < 20; n++) begin
         op(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) tick;
      end
      repeat (12) tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
